// File: rtl/serial_bit_feeder_if.sv
// Load-side valid/ready handshake of the serial bit feeder.
// The producer side is the master and the feeder side is the slave.
interface serial_bit_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] par_in;
  logic             load_valid;
  logic             load_ready;

  modport master (output par_in, output load_valid, input load_ready);
  modport slave  (input par_in, input load_valid, output load_ready);
endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: WIDTH-bit words in, one bit per clock out, gapless between words.
// Optional `define SER_PARITY_EN appends an even-parity bit after each word.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_bit_feeder_if.slave   ld,
  output logic                 d_out,
  output logic                 bit_valid,
  output logic                 last_bit
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_PARITY = 2'd2} state_t;
  localparam logic LAST_ON_LOAD = 1'b0;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1} state_t;
  localparam logic LAST_ON_LOAD = (WIDTH == 1);
`endif

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             d_out_q, d_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             last_bit_q, last_bit_d;
  logic             parity_q, parity_d;
  logic             accept;

  // The shift register holds the not-yet-presented bits already aligned so head_bit() is next.
`ifdef SER_PARITY_EN
  assign ld.load_ready = (state_q == ST_IDLE) | (state_q == ST_PARITY);
`else
  assign ld.load_ready = (state_q == ST_IDLE) | ((state_q == ST_SHIFT) & last_bit_q);
`endif
  assign accept    = ld.load_valid & ld.load_ready;
  assign d_out     = d_out_q;
  assign bit_valid = bit_valid_q;
  assign last_bit  = last_bit_q;

  // Next-state and next-output computation
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    parity_d    = parity_q;
    d_out_d     = 1'b0;
    bit_valid_d = 1'b0;
    last_bit_d  = 1'b0;
    if (accept) begin
      state_d     = ST_SHIFT;
      d_out_d     = head_bit(ld.par_in);
      shift_d     = advance(ld.par_in);
      cnt_d       = CNT_LOAD;
      parity_d    = even_parity(ld.par_in);
      bit_valid_d = 1'b1;
      last_bit_d  = LAST_ON_LOAD;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (cnt_q != {CW{1'b0}}) begin
            d_out_d     = head_bit(shift_q);
            shift_d     = advance(shift_q);
            cnt_d       = cnt_q - CW'(1);
            bit_valid_d = 1'b1;
`ifdef SER_PARITY_EN
            last_bit_d  = 1'b0;
`else
            last_bit_d  = (cnt_q == CW'(1));
`endif
          end else begin
`ifdef SER_PARITY_EN
            state_d     = ST_PARITY;
            d_out_d     = parity_q;
            bit_valid_d = 1'b1;
            last_bit_d  = 1'b1;
`else
            state_d     = ST_IDLE;
`endif
          end
        end
`ifdef SER_PARITY_EN
        ST_PARITY: state_d = ST_IDLE;
`endif
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= {WIDTH{1'b0}};
      cnt_q       <= {CW{1'b0}};
      parity_q    <= 1'b0;
      d_out_q     <= 1'b0;
      bit_valid_q <= 1'b0;
      last_bit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      parity_q    <= parity_d;
      d_out_q     <= d_out_d;
      bit_valid_q <= bit_valid_d;
      last_bit_q  <= last_bit_d;
    end
  end

endmodule
